// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Total clock cycles occupied by one frame on the line.
  function automatic int frame_cycles(input int data_w, input int clks_per_bit,
                                      input int parity, input int stop_bits);
    return (1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Word FIFO with show-ahead read so the transmitter can pop and load in one cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame FSM with optional parity and 1/2 stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              transmit,
  output logic              ready,
  output logic              txd,
  output logic              busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);

  state_t            r_state, w_state_next;
  logic [TW-1:0]     r_timer, w_timer_next;
  logic [IW-1:0]     r_index, w_index_next;
  logic [DATA_W-1:0] r_shift, w_shift_next;
  logic              r_parity, w_parity_next;
  logic              r_txd, w_txd_next;
  logic              r_busy;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_bit_end;
  logic [DATA_W-1:0] w_fifo_data;

  uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (transmit),
    .i_wdata (data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign ready     = !w_full;
  assign txd       = r_txd;
  assign busy      = r_busy;
  assign w_bit_end = (r_timer == TW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = w_bit_end ? '0 : r_timer + 1'b1;
    w_index_next  = r_index;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_next = '0;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_next  = w_fifo_data;
          w_parity_next = (^w_fifo_data) ^ (PARITY == PAR_ODD);
          w_state_next  = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_index_next = '0;
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_index == IW'(DATA_W - 1)) begin
            w_index_next = '0;
            w_state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_index_next = r_index + 1'b1;
            w_shift_next = r_shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_index == IW'(STOP_BITS - 1)) begin
            w_index_next = '0;
            // Chain straight into the next start bit when more words are queued.
            if (!w_empty) begin
              w_pop         = 1'b1;
              w_shift_next  = w_fifo_data;
              w_parity_next = (^w_fifo_data) ^ (PARITY == PAR_ODD);
              w_state_next  = ST_START;
            end else begin
              w_state_next = ST_IDLE;
            end
          end else begin
            w_index_next = r_index + 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_txd_next = 1'b1;
    case (r_state)
      ST_START:  w_txd_next = 1'b0;
      ST_DATA:   w_txd_next = r_shift[0];
      ST_PARITY: w_txd_next = r_parity;
      default:   w_txd_next = 1'b1;
    endcase
  end

  // txd and busy are registered one cycle behind the state so the line is glitch-free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_index  <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_index  <= w_index_next;
      r_shift  <= w_shift_next;
      r_parity <= w_parity_next;
      r_txd    <= w_txd_next;
      r_busy   <= (r_state != ST_IDLE) || !w_empty;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 868, clk cycles per bit period; legal minimum 2.
REQ-003 Parameter PARITY, default 0, parity mode; 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, word buffer depth; power of two, at least 2.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 data  input  DATA_W  word to transmit.
REQ-009 transmit  input  1  valid strobe; data is accepted on any edge where transmit and ready are both high.
REQ-010 ready  output  1  high when the FIFO is not full.
REQ-011 txd  output  1  serial line; idles high.
REQ-012 busy  output  1  high while a frame is in progress or the FIFO is non-empty.

Function
REQ-013 Frame order: start bit (0), DATA_W data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
REQ-014 Each bit is held on txd for exactly CLKS_PER_BIT cycles.
- The bit timer counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
REQ-015 Frame length in cycles: (1 + DATA_W + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT.
REQ-016 Parity is computed from the popped word.
- Even mode: the XOR of the data bits.
- Odd mode: the inverse of that XOR.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when the FIFO is non-empty; the word is popped in the same cycle.
- START -> DATA after one bit period.
- DATA -> PARITY, or -> STOP when PARITY=0, after DATA_W bit periods.
- PARITY -> STOP after one bit period.
- STOP -> START if the FIFO is non-empty at the end of the last stop period; otherwise -> IDLE.
REQ-018 Latency: a word accepted at edge N into an empty FIFO while IDLE drives txd low from edge N+2.
REQ-019 Back-to-back frames have zero idle cycles between the last stop bit and the next start bit.
REQ-020 When the FIFO is full, ready is low and transmit is ignored; no overwrite occurs and no error is flagged.
REQ-021 A push and a pop in the same cycle are both honoured; the occupancy count is unchanged.
REQ-022 Words are transmitted in acceptance order; the FIFO pointers wrap modulo FIFO_DEPTH.
REQ-023 busy rises on the edge after the first acceptance and falls on the edge that ends the final stop bit with the FIFO empty.

Reset
REQ-024 While reset is low at a rising edge:
- txd=1, ready=1, busy=0, FSM=IDLE, bit timer=0, bit index=0.
- FIFO pointers and count are cleared; any queued words are discarded.
REQ-025 A reset asserted mid-frame aborts the frame; txd is high from the next edge, and no partial-frame resumption occurs.
REQ-026 transmit is ignored in any cycle where reset is low.

Structure
REQ-027 Package uart_pkg holds the FSM state enum, the parity-mode constants (PAR_NONE/PAR_EVEN/PAR_ODD) and a frame-length function.
REQ-028 The FIFO is a separate sub-module, uart_fifo, parametrised by width and depth, with full/empty flags and a synchronous active-low reset.
REQ-029 The FSM, bit timer, shift register and parity logic reside in uart_tx_fifo.

Verification
REQ-030 DATA_W=8, CLKS_PER_BIT=4, PARITY=1, STOP_BITS=1; push 0xA5.
- txd bits: 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles (44 cycles total).
- Start bit falls 2 edges after acceptance.
REQ-031 DATA_W=7, PARITY=2, STOP_BITS=2; push 0x03.
- Parity bit = 1, followed by two stop periods.
- Frame = 11*CLKS_PER_BIT cycles.
REQ-032 FIFO_DEPTH=4; hold transmit high for 10 cycles with incrementing data starting at 0x10.
- Exactly 5 words are accepted (0x10..0x14), then ready goes low.
- All 5 are transmitted in order with no inter-frame gap.
- busy falls after the fifth stop bit.
REQ-033 Assert reset low for 1 cycle during the DATA state of a 0x55 frame.
- txd=1 on the next edge, busy=0, ready=1.
- No further frame appears.
REQ-034 PARITY=0, STOP_BITS=1, CLKS_PER_BIT=2; push 0x00 then 0xFF.
- txd: 0 for 18 cycles, then 1 for 2 cycles (stop), then 0 for 2 cycles (start), then 1 for 18 cycles.
